hand_centroid_tracker: RTL
==========================

Name: hand_centroid_tracker

Overview:
- Upstream of game_logic_and_renderer; produces one hand/marker coordinate per camera frame.
- Consumes a pixel stream with a per-pixel colour-match mask.
- Accumulates the coordinate sums and matched-pixel count over each frame. At frame end, divides sequentially to produce the centroid, drives hand_x/hand_y-compatible 12-bit outputs, and pulses valid.

Parameters:
MIN_AREA, 16, minimum matched-pixel count for a frame's centroid to be accepted
DIV_BITS, 30, dividend width and divider iteration count

Ports:
clk_in  input  1  system clock (65 MHz pixel clock)
rst_in_n  input  1  asynchronous, active-low reset
x_in  input  11  pixel column, 0-1023
y_in  input  10  pixel row, 0-767
valid_in  input  1  x_in/y_in/mask_in valid this cycle
mask_in  input  1  pixel matches marker colour
frame_done_in  input  1  single-cycle pulse, last pixel of frame delivered
x_out  output  12  centroid column, zero-extended
y_out  output  12  centroid row, zero-extended
area_out  output  20  matched-pixel count of last completed frame
found_out  output  1  last completed frame met MIN_AREA
valid_out  output  1  one-cycle pulse, result registers updated
busy_out  output  1  divider running

Behaviour:
- Reset: async on rst_in_n low. All outputs are 0, accumulators are 0, and the FSM is IDLE. Reset mid-divide aborts the divide with no valid_out.
- Accumulators:
  - sum_x is 30 bits, sum_y is 30 bits, count is 20 bits.
  - On valid_in & mask_in, add x_in to sum_x, add y_in to sum_y, and increment count.
  - Widths cover the worst case of 1024x768 all-matched (count ≤ 786432, sums < 2^30). No saturation logic.
- Frame close: frame_done_in is sampled at edge T.
  - A matched pixel in the same cycle as frame_done_in belongs to the closing frame.
  - At edge T, the closing sums plus that pixel are latched into divider registers.
  - In the same edge, the accumulators are cleared to 0 (next-frame pixels start at T+1).
- FSM IDLE -> DIVIDE -> DONE -> IDLE:
  - IDLE: on frame_done_in, latch and go to DIVIDE.
    - If the latched count < MIN_AREA, skip the divide and go to DONE with found=0.
  - DIVIDE: two parallel restoring dividers (sum_x/count, sum_y/count), one quotient bit per cycle, MSB first, DIV_BITS cycles. busy_out is 1 throughout DIVIDE.
  - DONE: one cycle.
    - valid_out = 1.
    - area_out = latched count.
    - found_out = (count ≥ MIN_AREA).
    - If found, x_out/y_out take the quotients, floor rounding, low bits zero-extended.
    - If not found, x_out/y_out hold their previous values.
- Latency:
  - Found frame: valid_out is high in the cycle following edge T+DIV_BITS+1, i.e. 32 cycles after the frame_done_in edge with the default parameters.
  - Not-found frame: valid_out is high after edge T+1.
- frame_done_in while busy (DIVIDE or DONE):
  - Accumulators still clear, so that frame is discarded.
  - The in-flight divide is unaffected.
  - No extra valid_out is produced.
- valid_in low: no accumulation regardless of mask_in.
- count = 0 always fails MIN_AREA ≥ 1, so there is never a divide-by-zero. MIN_AREA = 0 is illegal.
- Outputs are registered. x_out, y_out, area_out, and found_out are stable between valid_out pulses.

Test Plan:
- Single matched pixel (100,200) with MIN_AREA=1, then frame_done -> 32 cycles later valid_out=1 for 1 cycle; x_out=100, y_out=200, area_out=1, found_out=1.
- 10x10 block at x 50-59, y 20-29, MIN_AREA=16 -> area_out=100, x_out=54 (5450/100 floored), y_out=24, found_out=1.
- Next frame with 5 matched pixels -> valid_out at T+2, found_out=0, area_out=5, x_out=54 and y_out=24 held.
- Matched pixel (7,3) coincident with frame_done_in, MIN_AREA=1, no other pixels -> x_out=7, y_out=3, area_out=1. A pixel at T+1 counts only toward the following frame.
- Second frame_done_in 10 cycles into a divide -> exactly one valid_out carrying the first frame's result. The next frame's accumulation starts from 0.
- rst_in_n low for 1 cycle mid-DIVIDE -> outputs are immediately 0, busy_out=0, and no valid_out. The next frame then completes normally.

Source files
------------

// File: rtl/hand_centroid_tracker.sv
// rtl/hand_centroid_tracker.sv - per-frame colour-mask centroid with sequential divide
module hand_centroid_tracker #(
    parameter int MIN_AREA = 16,
    parameter int DIV_BITS = 30
) (
    input  logic        clk_in,
    input  logic        rst_in_n,
    input  logic [10:0] x_in,
    input  logic [9:0]  y_in,
    input  logic        valid_in,
    input  logic        mask_in,
    input  logic        frame_done_in,
    output logic [11:0] x_out,
    output logic [11:0] y_out,
    output logic [19:0] area_out,
    output logic        found_out,
    output logic        valid_out,
    output logic        busy_out
);

    localparam int CW = $clog2(DIV_BITS + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DIVIDE = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    logic [1:0]          state;
    logic [DIV_BITS-1:0] sum_x, sum_y;
    logic [19:0]         count;
    logic [DIV_BITS-1:0] nxt_sum_x, nxt_sum_y;
    logic [19:0]         nxt_count;
    logic                pix;
    logic                area_ok;

    // Divider working registers: the dividend registers become the quotients
    logic [DIV_BITS-1:0] dvd_x, dvd_y;
    logic [19:0]         rem_x, rem_y;
    logic [19:0]         dsr;
    logic [CW-1:0]       iter;
    logic                found_lat;

    logic [20:0]         sh_x, sh_y;
    logic                ge_x, ge_y;
    logic [19:0]         nrem_x, nrem_y;

    assign pix      = valid_in & mask_in;
    assign busy_out = (state == S_DIVIDE);

    // Running sums including this cycle's pixel, so a pixel on frame_done joins the closing frame
    always_comb begin
        nxt_sum_x = sum_x + (pix ? DIV_BITS'(x_in) : '0);
        nxt_sum_y = sum_y + (pix ? DIV_BITS'(y_in) : '0);
        nxt_count = count + (pix ? 20'd1 : 20'd0);
        area_ok   = (nxt_count >= 20'(MIN_AREA));
    end

    // One restoring-division step per axis; remainder stays below the divisor so 20 bits suffice
    always_comb begin
        sh_x   = {rem_x, dvd_x[DIV_BITS-1]};
        sh_y   = {rem_y, dvd_y[DIV_BITS-1]};
        ge_x   = (sh_x >= {1'b0, dsr});
        ge_y   = (sh_y >= {1'b0, dsr});
        nrem_x = ge_x ? 20'(sh_x - {1'b0, dsr}) : sh_x[19:0];
        nrem_y = ge_y ? 20'(sh_y - {1'b0, dsr}) : sh_y[19:0];
    end

    // Accumulate matched pixels; every frame_done clears, even while busy, discarding that frame
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            sum_x <= '0;
            sum_y <= '0;
            count <= '0;
        end else if (frame_done_in) begin
            sum_x <= '0;
            sum_y <= '0;
            count <= '0;
        end else begin
            sum_x <= nxt_sum_x;
            sum_y <= nxt_sum_y;
            count <= nxt_count;
        end
    end

    // Frame-close FSM: latch, divide MSB first, then publish results for one cycle
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state     <= S_IDLE;
            dvd_x     <= '0;
            dvd_y     <= '0;
            rem_x     <= '0;
            rem_y     <= '0;
            dsr       <= '0;
            iter      <= '0;
            found_lat <= 1'b0;
            x_out     <= '0;
            y_out     <= '0;
            area_out  <= '0;
            found_out <= 1'b0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (frame_done_in) begin
                        dvd_x     <= nxt_sum_x;
                        dvd_y     <= nxt_sum_y;
                        dsr       <= nxt_count;
                        rem_x     <= '0;
                        rem_y     <= '0;
                        iter      <= '0;
                        found_lat <= area_ok;
                        state     <= area_ok ? S_DIVIDE : S_DONE;
                    end
                end
                S_DIVIDE: begin
                    rem_x <= nrem_x;
                    rem_y <= nrem_y;
                    dvd_x <= {dvd_x[DIV_BITS-2:0], ge_x};
                    dvd_y <= {dvd_y[DIV_BITS-2:0], ge_y};
                    iter  <= iter + 1'b1;
                    if (iter == CW'(DIV_BITS - 1)) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    valid_out <= 1'b1;
                    area_out  <= dsr;
                    found_out <= found_lat;
                    if (found_lat) begin
                        x_out <= dvd_x[11:0];
                        y_out <= dvd_y[11:0];
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
